// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the Stein binary GCD engine.
// Optional iteration counter is enabled with the GCD_ITER_CNT_EN macro.
package gcd_pkg;

    localparam int GCD_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIGN  = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // One datapath action per cycle, decoded by the controller.
    typedef enum logic [3:0] {
        DP_HOLD       = 4'd0,
        DP_LOAD       = 4'd1,
        DP_LOAD_ZERO  = 4'd2,
        DP_SHIFT_BOTH = 4'd3,
        DP_SHR_A      = 4'd4,
        DP_SHR_B      = 4'd5,
        DP_SUB_A      = 4'd6,
        DP_SUB_B      = 4'd7,
        DP_RES_AB     = 4'd8
    } dp_op_e;

    function automatic int gcd_max_cyc(input int width);
        return 4 * width + 2;
    endfunction

    function automatic int gcd_cnt_width(input int max_cyc);
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/gcd_stein_dp.sv
// Stein GCD datapath: a/b operands, common-power-of-two count k and result
// register, updated by one decoded action per cycle.
module gcd_stein_dp
    import gcd_pkg::*;
#(
    parameter int number_width = GCD_DEFAULT_WIDTH
)
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  dp_op_e                  op_i,
    input  logic [number_width-1:0] a_in_i,
    input  logic [number_width-1:0] b_in_i,
    output logic                    a_lsb_o,
    output logic                    b_lsb_o,
    output logic                    eq_o,
    output logic                    a_gt_b_o,
    output logic [number_width-1:0] res_o
);

    localparam int K_W = $clog2(number_width);

    logic [number_width-1:0] a_q, a_d;
    logic [number_width-1:0] b_q, b_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [number_width-1:0] res_q, res_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        k_d   = k_q;
        res_d = res_q;
        case (op_i)
            DP_LOAD: begin
                a_d = a_in_i;
                b_d = b_in_i;
                k_d = '0;
            end
            DP_LOAD_ZERO: begin
                a_d   = a_in_i;
                b_d   = b_in_i;
                k_d   = '0;
                res_d = a_in_i | b_in_i;
            end
            DP_SHIFT_BOTH: begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                k_d = k_q + K_W'(1);
            end
            DP_SHR_A:  a_d = a_q >> 1;
            DP_SHR_B:  b_d = b_q >> 1;
            // The larger operand is always the minuend, so no underflow.
            DP_SUB_A:  a_d = a_q - b_q;
            DP_SUB_B:  b_d = b_q - a_q;
            DP_RES_AB: res_d = a_q << k_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            k_q   <= k_d;
            res_q <= res_d;
        end
    end

    assign a_lsb_o  = a_q[0];
    assign b_lsb_o  = b_q[0];
    assign eq_o     = (a_q == b_q);
    assign a_gt_b_o = (a_q > b_q);
    assign res_o    = res_q;

endmodule

// File: rtl/gcd_stein_unit.sv
// Stein binary GCD engine with ready/valid on both sides, one op in flight.
// Define GCD_ITER_CNT_EN to add the iter_cnt output (cycles spent in ALIGN/REDUCE).
module gcd_stein_unit
    import gcd_pkg::*;
#(
    parameter int number_width = GCD_DEFAULT_WIDTH,
    parameter int MAX_CYC      = gcd_max_cyc(number_width)
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [number_width-1:0] a_in,
    input  logic [number_width-1:0] b_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [number_width-1:0] res,
    output logic                    zero_in,
    output logic                    busy,
    output state_e                  state_dbg
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [gcd_cnt_width(MAX_CYC)-1:0] iter_cnt
`endif
);

    if (number_width < 2 || MAX_CYC < 4 * number_width + 2) begin : g_param_check
        $error("gcd_stein_unit: number_width must be >= 2 and MAX_CYC >= 4*number_width+2");
    end

    state_e state_q;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   busy_q;
    logic   zero_in_q;

    dp_op_e dp_op;
    logic   a_lsb, b_lsb, eq, a_gt_b;
    logic   accept;
    logic   ops_zero;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and
    // res/zero_in stay frozen while out_valid waits for out_ready.
    assign accept   = (state_q == S_IDLE) && in_valid;
    assign ops_zero = (a_in == '0) || (b_in == '0);

    always_comb begin
        dp_op = DP_HOLD;
        case (state_q)
            S_IDLE: begin
                if (in_valid) dp_op = ops_zero ? DP_LOAD_ZERO : DP_LOAD;
            end
            S_ALIGN: begin
                if (!a_lsb && !b_lsb) dp_op = DP_SHIFT_BOTH;
            end
            S_REDUCE: begin
                if (eq)          dp_op = DP_RES_AB;
                else if (!a_lsb) dp_op = DP_SHR_A;
                else if (!b_lsb) dp_op = DP_SHR_B;
                else if (a_gt_b) dp_op = DP_SUB_A;
                else             dp_op = DP_SUB_B;
            end
            default: dp_op = DP_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            zero_in_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (ops_zero) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            zero_in_q   <= 1'b1;
                        end else begin
                            state_q   <= S_ALIGN;
                            busy_q    <= 1'b1;
                            zero_in_q <= 1'b0;
                        end
                    end
                end
                S_ALIGN: begin
                    if (a_lsb || b_lsb) state_q <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (eq) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    gcd_stein_dp #(
        .number_width(number_width)
    ) u_dp (
        .clk_i   (clk),
        .rst_ni  (rst),
        .op_i    (dp_op),
        .a_in_i  (a_in),
        .b_in_i  (b_in),
        .a_lsb_o (a_lsb),
        .b_lsb_o (b_lsb),
        .eq_o    (eq),
        .a_gt_b_o(a_gt_b),
        .res_o   (res)
    );

`ifdef GCD_ITER_CNT_EN
    localparam int CNT_W = gcd_cnt_width(MAX_CYC);
    logic [CNT_W-1:0] iter_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt_q <= '0;
        end else if (accept) begin
            iter_cnt_q <= '0;
        end else if (state_q == S_ALIGN || state_q == S_REDUCE) begin
            iter_cnt_q <= iter_cnt_q + CNT_W'(1);
        end
    end

    assign iter_cnt = iter_cnt_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign zero_in   = zero_in_q;
    assign state_dbg = state_q;

endmodule
